// File: rtl/instruction_fetch_stage.sv
// Purpose : Quinta front end; owns the PC, issues in-order word fetches and
//           presents fetched {pc, instruction} to decode via an output register.
// Latency : response captured at edge t is visible on the outputs after edge t+1.
// Backpr. : decode stall holds the outputs; requests stop once in-flight plus
//           buffered words reach FIFO_DEPTH; branch redirects flush and drop stale words.
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   imem_req_valid/ready/addr     fetch request channel (valid/ready)
//   imem_rsp_valid/data           in-order fetch responses (valid only)
//   stall                         decode hold
//   branch_taken/branch_target    redirect from execute
//   instruction/pc/instruction_valid   registered output to decode

// Generic synchronous FIFO with flush. DEPTH must be a power of two (>= 2).
// Latency: a pushed entry can be popped from the next cycle (no bypass).
// Backpressure: pushes while full are dropped unless a pop frees a slot.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_vld_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_rdy_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_rdy_i && (count_q != '0);
  assign do_push = push_vld_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
endmodule

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instruction_valid
);
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    logic [31:0]  pc;
    instruction_t word;
  } fetch_entry_t;

  localparam int           CW        = $clog2(FIFO_DEPTH) + 1;
  localparam instruction_t NOP       = 32'h0000_0013;
  localparam logic [31:0]  START_PC  = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0]  CREDITS   = (CW+1)'(FIFO_DEPTH);

  // Program counter and flow-control counters.
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Output register.
  instruction_t  instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic          vld_q, vld_d;

  // Queue/FIFO handshakes.
  logic          flushing;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_keep;
  logic          tag_pop;
  logic          fifo_pop;
  logic [31:0]   tag_dat;
  logic [CW-1:0] tag_count;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  fetch_entry_t  push_entry;
  fetch_entry_t  pop_entry;
  logic [63:0]   pop_raw;

  // Non-zero drop count means stale responses from before a redirect are
  // still on their way and must be discarded.
  assign flushing = (drop_cnt_q != '0);

  // Words in flight plus words buffered share one credit pool, so the FIFO
  // can always absorb every response that comes back.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !flushing && !branch_taken && (credits_used < CREDITS);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (e.g. one issued before a reset)
  // is not ours and changes nothing.
  assign rsp_take = imem_rsp_valid && (outstanding_q != '0);

  // The tag queue only holds tags for live requests; it is flushed on a
  // redirect, so stale responses must not pop it.
  assign tag_pop  = rsp_take && !flushing;
  assign rsp_keep = tag_pop && !branch_taken;

  assign fifo_pop = !branch_taken && !stall && (fifo_count != '0);

  assign push_entry.pc   = tag_dat;
  assign push_entry.word = imem_rsp_data;
  assign pop_entry       = fetch_entry_t'(pop_raw);

  fetch_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (branch_taken),
    .push_vld_i(req_fire),
    .push_dat_i(fetch_pc_q),
    .pop_rdy_i (tag_pop),
    .pop_dat_o (tag_dat),
    .count_o   (tag_count)
  );

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_prefetch_q (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (branch_taken),
    .push_vld_i(rsp_keep),
    .push_dat_i(push_entry),
    .pop_rdy_i (fifo_pop),
    .pop_dat_o (pop_raw),
    .count_o   (fifo_count)
  );

  // Counter and PC next state.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    drop_cnt_d    = drop_cnt_q;

    if (branch_taken) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      // Everything still outstanding after this cycle's response is stale.
      // No request fires this cycle, so outstanding_d is exactly that count.
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (flushing && rsp_take) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  // Output register next state: redirect beats stall, stall beats pop.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    if (branch_taken) begin
      instr_d = NOP;
      vld_d   = 1'b0;
    end else if (!stall) begin
      if (fifo_pop) begin
        instr_d = pop_entry.word;
        pc_d    = pop_entry.pc;
        vld_d   = 1'b1;
      end else begin
        instr_d = NOP;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= START_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      instr_q       <= NOP;
      pc_q          <= '0;
      vld_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      vld_q         <= vld_d;
    end
  end

  assign instruction       = instr_q;
  assign pc                = pc_q;
  assign instruction_valid = vld_q;

  // Target low bits are ignored; the tag queue occupancy tracks outstanding
  // in FETCH mode and is not needed as a separate control.
  logic unused_ok;
  assign unused_ok = ^{branch_target[1:0], tag_count};
endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front end of the Quinta pipeline. It owns the program counter and issues in-order word fetches to instruction memory over a valid/ready request channel. Responses arrive on a valid-only channel with variable latency. Returned words are buffered in a small prefetch FIFO, then presented as `instruction`/`pc` to `instruction_decode_stage` through an output register that honours decode `stall` and execute-stage branch redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `FIFO_DEPTH`, default 4: prefetch entries (power of two, ≥2); also the cap on requests in flight plus words buffered.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous and active-high; all state is cleared immediately on assertion.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: fetch byte address, bits [1:0] always 0.
- `imem_rsp_valid` in 1: response word valid; responses arrive in request order.
- `imem_rsp_data` in 32: fetched instruction word.
- `stall` in 1: decode/hazard hold; output register keeps its value.
- `branch_taken` in 1: redirect request.
- `branch_target` in 32: redirect address, bits [1:0] ignored.
- `instruction` out 32 (instruction_t): instruction to decode.
- `pc` out 32: address of `instruction`.
- `instruction_valid` out 1: `instruction`/`pc` hold a real fetched instruction.

## Operation
- State:
  - `fetch_pc`
  - `outstanding` (0..FIFO_DEPTH)
  - `drop_cnt` (0..FIFO_DEPTH)
  - FIFO of {pc, word}
  - pc-tag queue, written at request acceptance
- Modes: FETCH when `drop_cnt`==0; FLUSH otherwise.
- Request rule: `imem_req_valid` = !rst && FETCH && !branch_taken && (`outstanding` + FIFO count < FIFO_DEPTH). `imem_req_addr` = `fetch_pc`.
- Request acceptance (valid && ready): tag `fetch_pc`, `fetch_pc` += 4 (wraps mod 2^32), `outstanding`++.
- Response in FETCH: push {tag, data} into FIFO and decrement `outstanding`.
- Response in FLUSH: discard it, decrement `outstanding` and `drop_cnt`. FLUSH → FETCH when `drop_cnt` reaches 0.
- Response with `outstanding`==0: ignored, no state change.
- Simultaneous acceptance and response: `outstanding` is unchanged.
- Output register:
  - If !stall and FIFO is non-empty: pop into `instruction`/`pc`, valid=1.
  - If !stall and FIFO is empty: load NOP 32'h0000_0013, pc unchanged, valid=0.
  - If stall: hold all three outputs.
- Redirect (`branch_taken`=1) has priority over stall and all fetch activity:
  - `fetch_pc` ← {target[31:2],2'b00}
  - FIFO and tag queue flushed
  - outputs ← NOP, valid=0, pc unchanged
  - `drop_cnt` ← `outstanding` after this cycle's response is counted
  - No request is issued in the redirect cycle.
- Redirect while already in FLUSH: `drop_cnt` is reloaded from current `outstanding`.
- `imem_req_addr` is held stable while valid && !ready. Valid may drop only on a redirect or reset.

## Timing
- Reset values:
  - `fetch_pc`=RESET_PC; counters 0; FIFO empty
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC
  - `instruction`=32'h0000_0013, `pc`=0, `instruction_valid`=0
- First request is asserted the cycle after `rst` deasserts.
- Latency: a response captured at edge t appears on the outputs after edge t+1 (no FIFO bypass). With 1-cycle memory, instruction_valid rises 2 cycles after request acceptance.
- Throughput: with memory latency 1 and FIFO_DEPTH=4, one instruction per cycle is sustained when stall=0.
- Stall: outputs hold; fetching continues until the credit limit is reached, then `imem_req_valid` drops.
- Reset mid-operation: all state clears at once; in-flight responses arriving after reset see `outstanding`=0 and are ignored.
- Redirect effect: the first target request is issued the cycle after `branch_taken` if `outstanding` was 0, otherwise after the last stale response drains.

## Test plan
- Reset with RESET_PC=0x100, ready=1, memory latency 1 returning addr-derived words:
  - Requests go to 0x100, 0x104, 0x108, …
  - Outputs show pc 0x100 valid from the 3rd post-reset edge, then one instruction per cycle.
- Stall held 5 cycles mid-stream:
  - Outputs freeze at pc 0x108.
  - No more than 4 requests are in flight or buffered.
  - After release, pcs resume at 0x10C with no gaps or duplicates.
- branch_taken with target 0x203 while 2 responses are outstanding:
  - Both stale responses are dropped and the output goes NOP/valid=0.
  - The next request is to 0x200, then pc 0x200 is delivered valid.
- imem_req_ready=0 for 3 cycles at addr 0x40:
  - valid and addr are held stable at 0x40.
  - After ready, exactly one acceptance occurs at 0x40.
- branch_taken and stall asserted together: the redirect wins and the outputs become NOP/valid=0 despite the stall.
- Async reset asserted mid-cycle with 3 responses outstanding:
  - Outputs take their reset values immediately.
  - Late responses are ignored.
  - Fetch restarts at RESET_PC.
